// File: rtl/btn_sw_ctrl_if.sv
// Data-bus port bundle for the switch/button peripheral.
// The core drives the master side; the peripheral answers with registered read data.
interface btn_sw_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (output req_i, we_i, addr_i, be_i, wdata_i, input rdata_o);
  modport slave  (input req_i, we_i, addr_i, be_i, wdata_i, output rdata_o);
endinterface

// File: rtl/btn_sw_ctrl.sv
// Switch/button input peripheral: 2-flop sync, tick-based debounce per pad,
// sticky W1C event register with maskable level interrupt, registered reads.
module btn_sw_ctrl_db #(
  parameter int DB_TICKS = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic d_i,
  output logic stable_o,
  output logic acc_o
);
  localparam int CW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;

  logic [CW-1:0] cnt;

  // acc_o flags the edge on which stable_o takes the new level
  assign acc_o = (d_i != stable_o) & tick_i & (cnt == CW'(DB_TICKS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_o <= 1'b0;
      cnt      <= '0;
    end else if (d_i == stable_o) begin
      cnt <= '0;
    end else if (tick_i) begin
      if (cnt == CW'(DB_TICKS - 1)) begin
        stable_o <= d_i;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module btn_sw_ctrl #(
  parameter int N_SW     = 16,
  parameter int N_BTN    = 5,
  parameter int TICK_DIV = 100000,
  parameter int DB_TICKS = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SW-1:0]  sw_i,
  input  logic [N_BTN-1:0] btn_i,
  btn_sw_ctrl_if.slave     bus,
  output logic             irq_o
);
  localparam int N_IN = N_SW + N_BTN;
  localparam int TW   = $clog2(TICK_DIV);

  logic [N_IN-1:0] sync1, sync2, stable, acc;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [8:0]      evt, irq_mask, ev_set, ev_clr;
  logic [31:0]     rd_val;
  logic            wr_en, rd_en;
  logic [1:0]      sel;
  logic            unused_bits;

  assign unused_bits = ^{bus.addr_i[31:4], bus.addr_i[1:0], bus.be_i[3:1], bus.wdata_i[31:9]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_i, sw_i};
      sync2 <= sync1;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  btn_sw_ctrl_db #(.DB_TICKS(DB_TICKS)) u_db [N_IN-1:0] (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .tick_i   (tick),
    .d_i      (sync2),
    .stable_o (stable),
    .acc_o    (acc)
  );

  assign sel   = bus.addr_i[3:2];
  assign wr_en = bus.req_i & bus.we_i & bus.be_i[0];
  assign rd_en = bus.req_i & ~bus.we_i;

  // Button events fire on accepted rising edges only; any switch change sets bit 8
  always_comb begin
    ev_set             = '0;
    ev_set[N_BTN-1:0]  = acc[N_IN-1:N_SW] & sync2[N_IN-1:N_SW];
    ev_set[8]          = |acc[N_SW-1:0];
    ev_clr             = (wr_en && sel == 2'd2) ? bus.wdata_i[8:0] : 9'd0;
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      2'd0: rd_val[N_SW-1:0]  = stable[N_SW-1:0];
      2'd1: rd_val[N_BTN-1:0] = stable[N_IN-1:N_SW];
      2'd2: rd_val[8:0]       = evt;
      default: rd_val[8:0]    = irq_mask;
    endcase
  end

  // Set is ORed in after the clear so a colliding event survives the W1C
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt         <= '0;
      irq_mask    <= '0;
      irq_o       <= 1'b0;
      bus.rdata_o <= '0;
    end else begin
      evt   <= (evt & ~ev_clr) | ev_set;
      irq_o <= |(evt & irq_mask);
      if (wr_en && sel == 2'd3) irq_mask <= bus.wdata_i[8:0];
      if (rd_en) bus.rdata_o <= rd_val;
    end
  end
endmodule

// File: tb/tb_btn_sw_ctrl.sv
// Directed bench for btn_sw_ctrl with TICK_DIV=4, DB_TICKS=3.
module tb_btn_sw_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = '0;
  logic [4:0]  btn = '0;
  logic        irq;
  int          vecs = 0;
  int          miss = 0;

  btn_sw_ctrl_if bus ();

  btn_sw_ctrl #(.N_SW(16), .N_BTN(5), .TICK_DIV(4), .DB_TICKS(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .sw_i   (sw),
    .btn_i  (btn),
    .bus    (bus.slave),
    .irq_o  (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns data sampled at the following negedge
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a;
    @(negedge clk);
    bus.req_i = 1'b0;
    d = bus.rdata_o;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d; bus.be_i = be;
    @(negedge clk);
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d, d0, d1;
    int          hit;
    logic        irq_prev;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.be_i = '0; bus.wdata_i = '0;

    // Reset values
    idle(3); rst_n = 1'b1; idle(1);
    rd(32'h0, d); chk("rst_sw", d, 32'h0);
    rd(32'h4, d); chk("rst_btn", d, 32'h0);
    rd(32'h8, d); chk("rst_evt", d, 32'h0);
    rd(32'hC, d); chk("rst_mask", d, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);

    // Asynchronous reset mid-debounce
    wr(32'hC, 32'h1FF, 4'h1);
    rd(32'hC, d); chk("mask_pre", d, 32'h1FF);
    btn[1] = 1'b1;
    idle(6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdata", bus.rdata_o, 32'h0);
    chk("arst_mask", {23'd0, dut.irq_mask}, 32'h0);
    chk("arst_tick", {30'd0, dut.tick_cnt}, 32'h0);
    @(negedge clk); btn[1] = 1'b0;
    idle(3); rst_n = 1'b1; idle(1);

    // Glitch of 6 cycles is shorter than 3 ticks
    btn[2] = 1'b1; idle(6); btn[2] = 1'b0; idle(20);
    rd(32'h4, d); chk("glitch_btn", d, 32'h0);
    rd(32'h8, d); chk("glitch_evt", d, 32'h0);

    // Clean press of button 0
    wr(32'hC, 32'h001, 4'h1);
    btn[0] = 1'b1;
    hit = 0; irq_prev = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      rd(32'h4, d);
      if (d[0] && hit == 0) begin
        hit = i;
        chk("press_irq_before", {31'd0, irq_prev}, 32'h0);
        chk("press_irq_after", {31'd0, irq}, 32'h1);
        break;
      end
      irq_prev = irq;
    end
    // Stable updated on the edge before the read that first showed it
    chk("press_latency_ok", {31'd0, (hit - 1 >= 9 && hit - 1 <= 14)}, 32'h1);
    rd(32'h8, d); chk("press_evt", d, 32'h001);
    btn[0] = 1'b0; idle(20);
    rd(32'h4, d); chk("release_btn", d, 32'h0);
    rd(32'h8, d); chk("release_evt", d, 32'h001);

    // W1C clear
    wr(32'h8, 32'h001, 4'h1);
    chk("w1c_irq_lag", {31'd0, irq}, 32'h1);
    @(negedge clk);
    chk("w1c_irq_drop", {31'd0, irq}, 32'h0);
    rd(32'h8, d); chk("w1c_evt", d, 32'h0);

    // Collision: W1C on the very edge the new press is accepted
    btn[0] = 1'b1;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dut.acc[16]) begin hit = 1; break; end
    end
    chk("coll_found", hit, 1);
    wr(32'h8, 32'h001, 4'h1);
    rd(32'h8, d); chk("coll_set_wins", d, 32'h001);

    // Switches with masking
    btn[0] = 1'b0;
    wr(32'hC, 32'h0, 4'h1);
    idle(20);
    wr(32'h8, 32'h1FF, 4'h1);
    sw = 16'hA5C3; idle(25);
    rd(32'h0, d); chk("sw_state", d, 32'h0000A5C3);
    rd(32'h8, d); chk("sw_evt", d, 32'h100);
    chk("sw_irq_masked", {31'd0, irq}, 32'h0);
    wr(32'hC, 32'h100, 4'h1);
    @(negedge clk);
    chk("sw_irq_unmasked", {31'd0, irq}, 32'h1);

    // Bus corner cases
    wr(32'h0, 32'hFFFF_FFFF, 4'hF);
    rd(32'h0, d); chk("wr_ro_ignored", d, 32'h0000A5C3);
    wr(32'hC, 32'h1FF, 4'b1110);
    rd(32'hC, d); chk("be0_ignored", d, 32'h100);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h0;
    @(negedge clk); d0 = bus.rdata_o;
    bus.addr_i = 32'h4;
    @(negedge clk); d1 = bus.rdata_o;
    bus.req_i = 1'b0;
    chk("b2b_first", d0, 32'h0000A5C3);
    chk("b2b_second", d1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/btn_sw_ctrl.md
# btn_sw_ctrl

Memory-mapped input peripheral for the board's slide switches and push-buttons: the read-side counterpart of the 7-segment display controller on the processor's data bus. Raw pad inputs are synchronized, debounced against a shared sample tick, and exposed to the core as readable state. Button presses and switch changes are latched as sticky events that drive a maskable interrupt. Read data is registered, with one cycle of latency.

## Interface
- `N_SW`, default 16: number of slide switches (1..16).
- `N_BTN`, default 5: number of push-buttons (1..8).
- `TICK_DIV`, default 100000: clk cycles per debounce sample tick (at least 2).
- `DB_TICKS`, default 10: consecutive differing samples required to accept a new level (at least 1).
- `clk_i` in, 1: system clock. One clock domain.
- `rst_ni` in, 1: reset, asynchronous and active-low.
- `sw_i` in, N_SW: raw switch pads, asynchronous.
- `btn_i` in, N_BTN: raw button pads, asynchronous, 1 = pressed.
- `req_i` in, 1: bus access strobe.
- `we_i` in, 1: 1 = write, 0 = read.
- `addr_i` in, 32: byte address. Only `addr_i[3:2]` is decoded.
- `be_i` in, 4: byte enables. Only `be_i[0]` is used for writes.
- `wdata_i` in, 32: write data.
- `rdata_o` out, 32: read data, registered.
- `irq_o` out, 1: level interrupt, registered.

## Operation
- **Register map** (`addr_i[3:2]`):
  - 0 SW_STATE, read-only: debounced switches in bits `[N_SW-1:0]`, zero-extended.
  - 1 BTN_STATE, read-only: debounced buttons in bits `[N_BTN-1:0]`.
  - 2 EVENT, read / write-1-to-clear: bit `b` (b < N_BTN) is set on a 0→1 transition of debounced button `b`. Bit 8 is set on any change of any debounced switch.
  - 3 IRQ_MASK, read/write: bits `[8:0]`, layout matches EVENT.
- **Writes** take effect when `req_i & we_i & be_i[0]`.
  - EVENT: each bit where `wdata_i` is 1 is cleared.
  - IRQ_MASK: loads `wdata_i[8:0]`.
  - Writes to addresses 0 and 1 are ignored.
- **Reads** (`req_i & ~we_i`): `rdata_o` is loaded with the addressed register on the next clock edge. It holds its value when there is no read. Unimplemented bits read as 0.
- **Synchronizer**: a two-flop synchronizer on every pad bit. Debounce sees only the synchronizer output.
- **Tick counter**: `tick_cnt` counts 0..TICK_DIV-1 and wraps. `tick` is high during the cycle when `tick_cnt == TICK_DIV-1`.
- **Debounce, per input**: a stable bit plus a counter of `$clog2(DB_TICKS)` bits (minimum 1).
  - If the synced value equals stable: the counter is 0.
  - If they differ, on a tick: when the counter equals DB_TICKS-1, stable takes the synced value and the counter goes to 0. Otherwise the counter increments.
  - If the synced value returns to stable before acceptance, the counter resets to 0 immediately, without waiting for a tick.
- **Event set** is computed from the old and new stable values in the same edge that updates stable.
- **Set/clear collision**: if a W1C clear and an event set hit the same bit in the same cycle, set wins.
- **Interrupt**: `irq_o <= |(EVENT & IRQ_MASK)`, registered.

## Timing
- **Reset**: `rst_ni` low asynchronously clears every register.
  - `rdata_o` = 0, `irq_o` = 0.
  - Synchronizers, stable bits, debounce counters, `tick_cnt`, EVENT and IRQ_MASK all = 0.
  - Reset mid-debounce discards partial counts. After release, a pad already held at 1 is accepted through a full debounce, as if it had just changed.
- **Read latency**: 1 cycle. Back-to-back reads return one result per cycle.
- **Write visibility**: a write is visible to a read issued in the next cycle. EVENT and IRQ_MASK changes reach `irq_o` one cycle after the register updates.
- **Pad-to-state latency**: 2 cycles of synchronization, then acceptance on the DB_TICKS-th tick that sees the differing value. Total is between (DB_TICKS-1)·TICK_DIV+3 and DB_TICKS·TICK_DIV+2 cycles.
- **Pad-to-IRQ latency**: the stable bit and the EVENT bit update on the same edge. `irq_o` follows one edge later.
- **Glitch rejection**: a pad pulse seen by the synchronizer for fewer than DB_TICKS consecutive ticks is never accepted and produces no event.

## Test plan
Bench parameters: TICK_DIV=4, DB_TICKS=3, N_SW=16, N_BTN=5.

1. **Reset values**: reset, then read addresses 0x0/0x4/0x8/0xC → all read 0 and `irq_o` = 0. Assert `rst_ni` low mid-debounce → all registers are 0 within the same cycle.
2. **Glitch rejection**: drive `btn_i[2]` high for 6 cycles → BTN_STATE stays 0 and EVENT stays 0.
3. **Clean press**:
   - Hold `btn_i[0]` = 1 and set IRQ_MASK = 0x001.
   - BTN_STATE reads 0x1 within 9–14 cycles of the pad change.
   - EVENT reads 0x001 and `irq_o` rises one cycle after the EVENT bit sets.
   - Release the button → EVENT is unchanged (release is not an event).
4. **W1C and collision**:
   - Write 0x001 to EVENT → bit 0 clears and `irq_o` drops the following cycle.
   - Arrange a new press to be accepted in the exact cycle of a W1C on bit 0 → bit 0 remains 1.
5. **Switches and masking**:
   - Set `sw_i` = 0xA5C3 with IRQ_MASK = 0 → SW_STATE reads 0xA5C3, EVENT bit 8 = 1, `irq_o` = 0.
   - Write IRQ_MASK = 0x100 → `irq_o` goes to 1.
6. **Bus corner cases**:
   - A write to address 0x0 leaves SW_STATE unchanged.
   - An IRQ_MASK write with `be_i` = 4'b1110 is ignored.
   - Back-to-back reads of 0x0 then 0x4 return their two values on consecutive cycles.
